// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between an integer-pipeline port (0) and an aux port (1).
// Latency: accept at cycle T, response valid at T+2; one op per 3 cycles at most.
// Backpressure: a held response stalls the arbiter; no request is accepted outside IDLE.
//
// Ports:
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_reqN_valid/o_reqN_ready           request handshake, N=0,1
//   i_reqN_rs1/i_reqN_rs2/i_reqN_ctrl   operands and 4-bit ALU control code
//   o_respN_valid/i_respN_ready         response handshake, N=0,1
//   o_respN_rd/o_respN_zero             captured ALU result and zero flag
//   o_alu_rs1/o_alu_rs2/o_alu_ctrl      drive the shared ALU (zero outside EXEC)
//   i_alu_rd/i_alu_zero                 shared ALU outputs (combinational)
//   o_busy                              high whenever an op is in flight
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [DATA_WIDTH-1:0] i_req0_rs1,
  input  logic [DATA_WIDTH-1:0] i_req0_rs2,
  input  logic [3:0]            i_req0_ctrl,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_rs1,
  input  logic [DATA_WIDTH-1:0] i_req1_rs2,
  input  logic [3:0]            i_req1_ctrl,
  output logic                  o_resp0_valid,
  input  logic                  i_resp0_ready,
  output logic [DATA_WIDTH-1:0] o_resp0_rd,
  output logic                  o_resp0_zero,
  output logic                  o_resp1_valid,
  input  logic                  i_resp1_ready,
  output logic [DATA_WIDTH-1:0] o_resp1_rd,
  output logic                  o_resp1_zero,
  output logic [DATA_WIDTH-1:0] o_alu_rs1,
  output logic [DATA_WIDTH-1:0] o_alu_rs2,
  output logic [3:0]            o_alu_ctrl,
  input  logic [DATA_WIDTH-1:0] i_alu_rd,
  input  logic                  i_alu_zero,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_prio;    // side that wins a tie; flips to the non-owner after each response
  logic                  r_owner;   // requester whose op is in flight
  logic [DATA_WIDTH-1:0] r_alu_rs1;
  logic [DATA_WIDTH-1:0] r_alu_rs2;
  logic [3:0]            r_alu_ctrl;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_zero;
  logic                  r_resp0_valid;
  logic                  r_resp1_valid;
  logic                  r_busy;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_resp_hs;

  // Ready is masked during reset so nothing appears accepted in the reset cycle.
  assign w_idle   = (r_state == S_IDLE) && !i_reset;
  assign w_grant0 = w_idle && i_req0_valid && (!i_req1_valid || !r_prio);
  assign w_grant1 = w_idle && i_req1_valid && (!i_req0_valid ||  r_prio);

  // Response valid is only ever set in RESP, so an early ready is simply ignored.
  assign w_resp_hs = (r_state == S_RESP) &&
                     (r_owner ? (r_resp1_valid && i_resp1_ready)
                              : (r_resp0_valid && i_resp0_ready));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_alu_rs1     <= '0;
      r_alu_rs2     <= '0;
      r_alu_ctrl    <= 4'h0;
      r_rd          <= '0;
      r_zero        <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            // Operand registers double as the ALU drive, so they are live exactly in EXEC.
            r_owner    <= w_grant1;
            r_alu_rs1  <= w_grant1 ? i_req1_rs1  : i_req0_rs1;
            r_alu_rs2  <= w_grant1 ? i_req1_rs2  : i_req0_rs2;
            r_alu_ctrl <= w_grant1 ? i_req1_ctrl : i_req0_ctrl;
            r_busy     <= 1'b1;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rd          <= i_alu_rd;
          r_zero        <= i_alu_zero;
          r_alu_rs1     <= '0;
          r_alu_rs2     <= '0;
          r_alu_ctrl    <= 4'h0;
          r_resp0_valid <= !r_owner;
          r_resp1_valid <=  r_owner;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_prio        <= !r_owner;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req0_ready  = w_grant0;
  assign o_req1_ready  = w_grant1;
  assign o_resp0_valid = r_resp0_valid;
  assign o_resp1_valid = r_resp1_valid;
  assign o_resp0_rd    = r_rd;
  assign o_resp1_rd    = r_rd;
  assign o_resp0_zero  = r_zero;
  assign o_resp1_zero  = r_zero;
  assign o_alu_rs1     = r_alu_rs1;
  assign o_alu_rs2     = r_alu_rs2;
  assign o_alu_ctrl    = r_alu_ctrl;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared ALU attached.
// Latency: checks accept at T, EXEC at T+1, response at T+2.
// Backpressure: holds response ready low and checks the arbiter stalls.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp0_rd, resp1_rd;
  logic        resp0_zero, resp1_zero;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_rs1(req0_rs1), .i_req0_rs2(req0_rs2), .i_req0_ctrl(req0_ctrl),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_rs1(req1_rs1), .i_req1_rs2(req1_rs2), .i_req1_ctrl(req1_ctrl),
    .o_resp0_valid(resp0_valid), .i_resp0_ready(resp0_ready),
    .o_resp0_rd(resp0_rd), .o_resp0_zero(resp0_zero),
    .o_resp1_valid(resp1_valid), .i_resp1_ready(resp1_ready),
    .o_resp1_rd(resp1_rd), .o_resp1_zero(resp1_zero),
    .o_alu_rs1(alu_rs1), .o_alu_rs2(alu_rs2), .o_alu_ctrl(alu_ctrl),
    .i_alu_rd(alu_rd), .i_alu_zero(alu_zero),
    .o_busy(busy)
  );

  // Shared ALU stand-in: codes 0x0..0xa, anything else yields 0.
  always_comb begin
    alu_rd = 32'h0;
    case (alu_ctrl)
      4'h1: alu_rd = alu_rs1 + alu_rs2;
      4'h2: alu_rd = alu_rs1 - alu_rs2;
      4'h3: alu_rd = alu_rs1 & alu_rs2;
      4'h4: alu_rd = alu_rs1 | alu_rs2;
      4'h5: alu_rd = alu_rs1 ^ alu_rs2;
      4'h6: alu_rd = alu_rs1 << alu_rs2[4:0];
      4'h7: alu_rd = alu_rs1 >> alu_rs2[4:0];
      4'h8: alu_rd = $unsigned($signed(alu_rs1) >>> alu_rs2[4:0]);
      4'h9: alu_rd = {31'h0, $signed(alu_rs1) < $signed(alu_rs2)};
      4'ha: alu_rd = {31'h0, alu_rs1 < alu_rs2};
      default: alu_rd = 32'h0;
    endcase
    alu_zero = (alu_ctrl == 4'h2) && (alu_rd == 32'h0);
  end

  typedef struct {
    logic        port;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] rd;
    logic        zero;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] ctrl);
    if (port) begin
      req1_valid = 1'b1; req1_rs1 = rs1; req1_rs2 = rs2; req1_ctrl = ctrl;
    end else begin
      req0_valid = 1'b1; req0_rs1 = rs1; req0_rs2 = rs2; req0_ctrl = ctrl;
    end
  endtask

  // Leaves the caller at the negedge of the cycle in which some ready is high.
  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no ready within 20 cycles, required a grant", name);
    end
  endtask

  task automatic run_op(input string tag, input logic port, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [3:0] ctrl,
                        input logic [31:0] exp_rd, input logic exp_zero);
    bit ok;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(port, rs1, rs2, ctrl);
    wait_ready({tag, "_wait"}, ok);
    if (ok) begin
      chk({tag, "_ready_own"},   {31'h0, port ? req1_ready : req0_ready}, 32'd1);
      chk({tag, "_ready_other"}, {31'h0, port ? req0_ready : req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);  // EXEC
      chk({tag, "_exec_busy"}, {31'h0, busy}, 32'd1);
      chk({tag, "_exec_ctrl"}, {28'h0, alu_ctrl}, {28'h0, ctrl});
      chk({tag, "_exec_rs1"},  alu_rs1, rs1);
      chk({tag, "_exec_rs2"},  alu_rs2, rs2);
      chk({tag, "_exec_noresp"}, {31'h0, resp0_valid | resp1_valid}, 32'd0);
      tick();
      @(negedge clk);  // RESP
      chk({tag, "_resp_valid"}, {31'h0, port ? resp1_valid : resp0_valid}, 32'd1);
      chk({tag, "_resp_other"}, {31'h0, port ? resp0_valid : resp1_valid}, 32'd0);
      chk({tag, "_rd"},   port ? resp1_rd : resp0_rd, exp_rd);
      chk({tag, "_zero"}, {31'h0, port ? resp1_zero : resp0_zero}, {31'h0, exp_zero});
      chk({tag, "_alu_idle"}, {28'h0, alu_ctrl}, 32'd0);
      tick();
      @(negedge clk);  // back in IDLE
      chk({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
      chk({tag, "_idle_resp"}, {31'h0, resp0_valid | resp1_valid}, 32'd0);
    end else begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [1:0] exp_owner;
    vecs[0] = '{1'b0, 32'd5,         32'd7,        4'h1, 32'd12,        1'b0};
    vecs[1] = '{1'b1, 32'h8000_0000, 32'd4,        4'h8, 32'hF800_0000, 1'b0};
    vecs[2] = '{1'b1, 32'h1234_5678, 32'd3,        4'hC, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 32'd9,         32'd9,        4'h2, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 32'd3,         32'd5,        4'h2, 32'hFFFF_FFFE, 1'b0};
    vecs[5] = '{1'b0, 32'hF0,        32'h0F,       4'h5, 32'hFF,        1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        4'h1, 32'h0,         1'b0};

    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rs1 = '0; req0_rs2 = '0; req0_ctrl = '0;
    req1_rs1 = '0; req1_rs2 = '0; req1_ctrl = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;  // early ready while idle must be ignored
    do_reset();

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_ready0", {31'h0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'h0, req1_ready}, 32'd0);
      chk("rst_resp0",  {31'h0, resp0_valid}, 32'd0);
      chk("rst_resp1",  {31'h0, resp1_valid}, 32'd0);
      chk("rst_ctrl",   {28'h0, alu_ctrl}, 32'd0);
      chk("rst_busy",   {31'h0, busy}, 32'd0);
      tick();
    end

    // Single-requester vectors
    for (int v = 0; v < 7; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].port, vecs[v].rs1, vecs[v].rs2,
             vecs[v].ctrl, vecs[v].rd, vecs[v].zero);
    end

    // Contention from prio 0: grants go 0,1,0
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(1'b0, 32'd9, 32'd9, 4'h2);
    set_req(1'b1, 32'hF0, 32'h0F, 4'h5);
    for (int k = 0; k < 3; k++) begin
      exp_owner = (k == 1) ? 2'd1 : 2'd0;
      wait_ready($sformatf("cont%0d_wait", k), ok);
      if (!ok) break;
      chk($sformatf("cont%0d_ready0", k), {31'h0, req0_ready}, {31'h0, exp_owner == 2'd0});
      chk($sformatf("cont%0d_ready1", k), {31'h0, req1_ready}, {31'h0, exp_owner == 2'd1});
      tick();
      @(negedge clk);
      chk($sformatf("cont%0d_exec_noready", k), {31'h0, req0_ready | req1_ready}, 32'd0);
      tick();
      @(negedge clk);
      if (exp_owner == 2'd0) begin
        chk($sformatf("cont%0d_resp0v", k), {31'h0, resp0_valid}, 32'd1);
        chk($sformatf("cont%0d_rd", k), resp0_rd, 32'h0);
        chk($sformatf("cont%0d_zero", k), {31'h0, resp0_zero}, 32'd1);
      end else begin
        chk($sformatf("cont%0d_resp1v", k), {31'h0, resp1_valid}, 32'd1);
        chk($sformatf("cont%0d_rd", k), resp1_rd, 32'hFF);
        chk($sformatf("cont%0d_zero", k), {31'h0, resp1_zero}, 32'd0);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Backpressure on port 1 while port 0 waits; prio is now 1
    resp0_ready = 1'b1;
    resp1_ready = 1'b0;
    set_req(1'b1, 32'd100, 32'd23, 4'h1);
    set_req(1'b0, 32'd1, 32'd1, 4'h1);
    wait_ready("bp_wait", ok);
    if (ok) begin
      chk("bp_ready1", {31'h0, req1_ready}, 32'd1);
      chk("bp_ready0", {31'h0, req0_ready}, 32'd0);
      tick();
      req1_valid = 1'b0;
      @(negedge clk);
      chk("bp_exec_ready0", {31'h0, req0_ready}, 32'd0);
      tick();
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("bp%0d_resp1v", c), {31'h0, resp1_valid}, 32'd1);
        chk($sformatf("bp%0d_rd", c), resp1_rd, 32'd123);
        chk($sformatf("bp%0d_ready0", c), {31'h0, req0_ready}, 32'd0);
        chk($sformatf("bp%0d_resp0v", c), {31'h0, resp0_valid}, 32'd0);
        chk($sformatf("bp%0d_busy", c), {31'h0, busy}, 32'd1);
        tick();
      end
      resp1_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'h0, resp1_valid}, 32'd1);
      tick();
      @(negedge clk);
      chk("bp_after_ready0", {31'h0, req0_ready}, 32'd1);
      chk("bp_after_resp1v", {31'h0, resp1_valid}, 32'd0);
      tick();
      req0_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("bp_req0_resp0v", {31'h0, resp0_valid}, 32'd1);
      chk("bp_req0_rd", resp0_rd, 32'd2);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Reset during EXEC discards the op and restores prio 0
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(1'b1, 32'd4, 32'd4, 4'h1);
    wait_ready("rx_wait", ok);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rx_in_exec", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rx%0d_resp", c), {31'h0, resp0_valid | resp1_valid}, 32'd0);
      chk($sformatf("rx%0d_busy", c), {31'h0, busy}, 32'd0);
      tick();
    end
    // Both offered: prio 0 wins; withdrawn before the edge so nothing is latched
    set_req(1'b0, 32'd1, 32'd1, 4'h1);
    set_req(1'b1, 32'd1, 32'd1, 4'h1);
    @(negedge clk);
    chk("rx_prio_ready0", {31'h0, req0_ready}, 32'd1);
    chk("rx_prio_ready1", {31'h0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rx_withdrawn_busy", {31'h0, busy}, 32'd0);
    tick();
    run_op("rx_req1", 1'b1, 32'h8000_0000, 32'd4, 4'h8, 32'hF800_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
